// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - shared widths, operand types and FSM encoding for the field-element multiplier
package fe_pkg;

    localparam int FE_N = 255;
    localparam int FE_W = 17;
    localparam int FE_D = FE_N / FE_W;

    typedef logic [FE_N-1:0]   fe_t;
    typedef logic [2*FE_N-1:0] fe_wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } fe_mul_state_t;

endpackage

// File: rtl/cla_add.sv
// rtl/cla_add.sv - unsigned adder with 4-bit carry-lookahead groups, sum truncated to WIDTH
//
// Ports:
//   x, y : WIDTH-bit addends
//   sum  : WIDTH-bit sum (carry out discarded; callers size WIDTH so none is lost)
// WIDTH must be a multiple of 4.
module cla_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum
);

    localparam int NG = WIDTH / 4;

    always_comb begin
        logic       carry;
        logic       c1;
        logic       c2;
        logic       c3;
        logic [3:0] gg;
        logic [3:0] pp;
        carry = 1'b0;
        sum   = '0;
        for (int k = 0; k < NG; k++) begin
            gg = x[4*k +: 4] & y[4*k +: 4];
            pp = x[4*k +: 4] ^ y[4*k +: 4];
            // Carries inside the group come straight from the group carry-in.
            c1 = gg[0] | (pp[0] & carry);
            c2 = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & carry);
            c3 = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & carry);
            sum[4*k +: 4] = pp ^ {c3, c2, c1, carry};
            carry = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0])
                  | (pp[3] & pp[2] & pp[1] & pp[0] & carry);
        end
    end

endmodule

// File: rtl/fe_mul_digit.sv
// rtl/fe_mul_digit.sv - combinational N x W unsigned multiplier (carry-save reduction + CLA)
//
// Ports:
//   a : N-bit multiplicand
//   d : W-bit digit of the multiplier
//   p : N+W-bit exact product a*d
module fe_mul_digit #(
    parameter int N = 255,
    parameter int W = 17
) (
    input  logic [N-1:0]   a,
    input  logic [W-1:0]   d,
    output logic [N+W-1:0] p
);

    localparam int PW = N + W;

    logic [PW-1:0] sv;
    logic [PW-1:0] cv;

    // Partial products are folded into a sum/carry pair with 3:2 compressors.
    // Bits pushed past PW by the carry shift are provably zero because
    // a*d < 2^PW, so arithmetic modulo 2^PW is exact.
    always_comb begin
        logic [PW-1:0] ae;
        logic [PW-1:0] pp;
        logic [PW-1:0] s_n;
        logic [PW-1:0] c_n;
        ae  = {{W{1'b0}}, a};
        pp  = '0;
        s_n = '0;
        c_n = '0;
        sv  = d[0] ? ae : '0;
        cv  = (d[1] ? ae : '0) << 1;
        for (int j = 2; j < W; j++) begin
            pp  = (d[j] ? ae : '0) << j;
            s_n = sv ^ cv ^ pp;
            c_n = ((sv & cv) | (sv & pp) | (cv & pp)) << 1;
            sv  = s_n;
            cv  = c_n;
        end
    end

    cla_add #(.WIDTH(PW)) u_final_add (
        .x   (sv),
        .y   (cv),
        .sum (p)
    );

endmodule

// File: rtl/fe_mul_seq.sv
// rtl/fe_mul_seq.sv - sequential 255x255 -> 510-bit multiplier, one B digit per cycle
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous abort to IDLE (only with FE_MUL_FLUSH_EN defined)
//   in_valid / in_ready  : operand handshake, a and b sampled on acceptance
//   a, b                 : N-bit operands, b consumed least-significant digit first
//   out_valid / out_ready: product handshake, prod held until accepted
//   prod                 : 2N-bit exact product a*b
//   busy                 : high while in MUL or DONE
// Optional feature macro: FE_MUL_FLUSH_EN.
module fe_mul_seq
    import fe_pkg::*;
#(
    parameter  int N = FE_N,
    parameter  int W = FE_W,
    localparam int D = N / W
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef FE_MUL_FLUSH_EN
    input  logic           flush,
`endif
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] prod,
    output logic           busy
);

    localparam int CW = $clog2(D);

    fe_mul_state_t  state;
    fe_mul_state_t  state_n;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   areg;
    logic [N-1:0]   breg;
    logic [2*N-1:0] acc;
    logic [N+W-1:0] pd;
    logic [N+W-1:0] acc_sum;
    logic           kill;

`ifdef FE_MUL_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    fe_mul_digit #(.N(N), .W(W)) u_digit (
        .a (areg),
        .d (breg[W-1:0]),
        .p (pd)
    );

    // Right-shifting accumulation: acc[2N-1:N] holds the running upper
    // partial sum, acc[N-1:0] collects retired W-bit digits from the top.
    // After D steps the retired digits fill the low half exactly.
    cla_add #(.WIDTH(N + W)) u_acc_add (
        .x   ({{W{1'b0}}, acc[2*N-1:N]}),
        .y   (pd),
        .sum (acc_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = MUL;
            MUL:     if (cnt == CW'(D - 1)) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            acc  <= '0;
            areg <= '0;
            breg <= '0;
        end else if (kill) begin
            cnt <= '0;
            acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        areg <= a;
                        breg <= b;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                MUL: begin
                    acc  <= {acc_sum, acc[N-1:W]};
                    breg <= breg >> W;
                    cnt  <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign prod = acc;

endmodule

// File: tb/tb_fe_mul_seq.sv
// tb/tb_fe_mul_seq.sv - directed and random self-checking bench for fe_mul_seq
module tb_fe_mul_seq;
    import fe_pkg::*;

    localparam int N = FE_N;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] prod;
    logic           busy;
`ifdef FE_MUL_FLUSH_EN
    logic           flush;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fe_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FE_MUL_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rnd_fe();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom;
        return t[N-1:0];
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of cycle 1 after acceptance.
    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
        a = av;
        b = bv;
        in_valid = 1'b1;
        check("in_ready_before_accept", 510'(in_ready), 510'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
    endtask

    task automatic wait_done(input bit rand_ready, output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (rand_ready) out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_handshake", 510'(in_ready), 510'd1);
        check("out_valid_after_handshake", 510'(out_valid), 510'd0);
    endtask

    task automatic run_directed(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                                input logic [2*N-1:0] exp);
        int lat;
        start_op(av, bv);
        wait_done(1'b0, lat);
        check({tag, "_latency"}, 510'(lat + 1), 510'd16);
        check({tag, "_prod"}, prod, exp);
        finish_op();
    endtask

    initial begin
        logic [N-1:0]   av;
        logic [N-1:0]   bv;
        logic [2*N-1:0] e;
        logic [2*N-1:0] ea;
        logic [2*N-1:0] eb;
        int             lat;
        int             stall;
        bit             rose;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
`ifdef FE_MUL_FLUSH_EN
        flush     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_in_ready", 510'(in_ready), 510'd1);
        check("reset_out_valid", 510'(out_valid), 510'd0);
        check("reset_busy", 510'(busy), 510'd0);
        check("reset_prod", prod, 510'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_directed("one_by_one", 255'd1, 255'd1, 510'd1);

        av = '1;
        e  = '1;
        e  = e - (510'd1 << 256) + 510'd2;
        run_directed("max_sq", av, av, e);

        av = '1;
        av = av - 255'd18;
        e  = (510'd1 << 256) - 510'd38;
        run_directed("p_times_2", av, 255'd2, e);

        bv = '1;
        run_directed("zero_a", 255'd0, bv, 510'd0);

        // Backpressure and ignored in_valid while busy.
        start_op(255'd12345, 255'd678);
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        a = 255'd99;
        b = 255'd99;
        check("mul_in_ready_low_a", 510'(in_ready), 510'd0);
        @(negedge clk);
        check("mul_in_ready_low_b", 510'(in_ready), 510'd0);
        in_valid = 1'b0;
        wait_done(1'b0, lat);
        check("bp_latency", 510'(lat + 4), 510'd16);
        in_valid = 1'b1;
        a = 255'd7;
        b = 255'd7;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 510'(out_valid), 510'd1);
            check("bp_prod", prod, 510'd8369910);
            check("done_in_ready_low", 510'(in_ready), 510'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        finish_op();
        @(negedge clk);
        check("no_stray_accept_a", 510'(busy), 510'd0);
        @(negedge clk);
        check("no_stray_accept_b", 510'(busy), 510'd0);

        // Asynchronous reset in cycle 7 of MUL.
        start_op(255'd11, 255'd13);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 510'(out_valid), 510'd0);
        check("midreset_busy", 510'(busy), 510'd0);
        check("midreset_in_ready", 510'(in_ready), 510'd1);
        check("midreset_prod", prod, 510'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_directed("after_reset", 255'd3, 255'd5, 510'd15);

        // Random back-to-back operands with random out_ready.
        for (int i = 0; i < 200; i++) begin
            av = rnd_fe();
            bv = rnd_fe();
            if (i == 0) av = '1;
            if (i == 1) bv = '0;
            ea = {{N{1'b0}}, av};
            eb = {{N{1'b0}}, bv};
            e  = ea * eb;
            start_op(av, bv);
            wait_done(1'b1, lat);
            check("rand_latency", 510'(lat + 1), 510'd16);
            check("rand_prod", prod, e);
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            finish_op();
        end

`ifdef FE_MUL_FLUSH_EN
        start_op(255'd5, 255'd7);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 510'(busy), 510'd0);
        check("flush_prod", prod, 510'd0);
        rose = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) rose = 1'b1;
            @(negedge clk);
        end
        check("flush_no_out_valid", 510'(rose), 510'd0);
        in_valid = 1'b1;
        a = 255'd9;
        b = 255'd9;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_discards_accept", 510'(busy), 510'd0);
        run_directed("after_flush", 255'd6, 255'd7, 510'd42);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fe_mul_seq.md
# fe_mul_seq

Sequential 255×255-bit field-element multiplier that produces the full 510-bit product consumed by the mod-p reduction stage of the Curve25519 datapath. Operand B is processed one W-bit digit per cycle against all of operand A, so one N×W multiplier array is reused instead of a full N×N array. Valid/ready handshakes on both sides let the block sit between the operand scheduler and the reduction stage. Latency is fixed and data-independent, as constant-time operation requires.

## Interface
Parameters:
- N, 255, operand width in bits
- W, 17, digit width of operand B; N % W == 0 required
- D, N/W (15), digit count; derived, not overridden

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a, b valid
- in_ready  out  1  block accepts operands
- a  in  N  multiplicand
- b  in  N  multiplier, consumed LSB digit first
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- prod  out  2N  product a×b, unsigned, exact
- busy  out  1  high in MUL or DONE

## Operation
- States: IDLE, MUL, DONE (2-bit encoding).
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, latch b into a shift register, clear acc (2N bits), set cnt=0, go to MUL.
- MUL, one digit per cycle:
  - d = breg[W-1:0].
  - acc <= acc + ((a × d) << (W·cnt)); breg <= breg >> W; cnt <= cnt+1.
  - An equivalent right-shifting accumulator (N+W-bit adder, low W bits retired per cycle) is permitted. It must give a bit-identical prod.
  - After the cycle with cnt == D-1, go to DONE.
- DONE:
  - out_valid=1 and prod=acc, both stable until handshake.
  - On out_ready go to IDLE.
- Arithmetic:
  - a × d is N+W bits.
  - acc never exceeds (2^N-1)^2 < 2^(2N), so no carry is ever lost.
  - No modular reduction inside this block.
- in_valid outside IDLE is ignored; in_ready=0 there, so no handshake occurs. a and b may change freely after acceptance.
- out_ready outside DONE has no effect.
- Zero digits are not skipped. Cycle count is independent of operand values.
- Reset, asynchronous and at any time including mid-MUL or in DONE:
  - state=IDLE, cnt=0, acc=0, breg=0.
  - Outputs: in_ready=1 (combinational from IDLE), out_valid=0, prod=0, busy=0.
  - Any in-flight operation is lost silently.

## Timing
- Accept handshake at edge E0. MUL occupies cycles 1..D. out_valid rises in cycle D+1 (16 cycles after E0 for defaults).
- With out_ready held high, out_valid lasts exactly one cycle and in_ready returns in cycle D+2.
- Throughput: one product per D+2 cycles (17 cycles for defaults).
- Backpressure: out_valid and prod hold indefinitely while out_ready=0.
- in_ready, out_valid and busy are decoded from the state register only, with no combinational path from inputs.
- prod is driven straight from the acc register.

## Configuration
- FE_MUL_FLUSH_EN:
  - Defined: adds input port flush (1 bit, synchronous). flush=1 in any state forces IDLE, cnt=0, acc=0, out_valid=0 on the next edge.
  - Priority: flush has priority over both handshakes in the same cycle. An in_valid handshake coinciding with flush is discarded, even though in_ready=1 in IDLE.
  - Not defined: the port does not exist and behaviour is as described above.

## Structure
- Package fe_pkg holds:
  - FE_N=255, FE_W=17, FE_D=15
  - typedef fe_t (logic [FE_N-1:0])
  - typedef fe_wide_t (logic [2*FE_N-1:0])
  - typedef enum fe_mul_state_t {IDLE, MUL, DONE}
- One sub-module, fe_mul_digit: a combinational N×W → N+W unsigned multiplier built as a carry-save tree plus the codebase's cla_add. It is instantiated once.
- Counter width is $clog2(D).

## Test plan
- a=1, b=1 → prod=1, out_valid 16 cycles after accept, in_ready back 17 cycles after accept.
- a=b=2^255-1 → prod=2^510-2^256+1; a=2^255-19, b=2 → prod=2^256-38; a=0, b=2^255-1 → prod=0, same 16-cycle latency.
- out_ready low 5 cycles in DONE → prod and out_valid stable for all 5 cycles; in_valid pulsed during MUL and DONE → no accept; next operand accepted only in IDLE.
- rst_n low for 1 cycle at cycle 7 of MUL → outputs at reset values immediately; next operation a=3, b=5 → prod=15, unaffected by the aborted one.
- 200 random back-to-back operand pairs with random out_ready → every prod equals the reference a×b, in order, none dropped or duplicated.
- FE_MUL_FLUSH_EN: flush at cycle 4 of MUL → IDLE next cycle, out_valid never rises; flush coincident with in_valid in IDLE → operand discarded.
